// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester byte streams, the tx_start/tx_busy transmitter
// handshake and the error/grant status of uart_tx_arbiter.
//   req/req_data/req_last   : requester i presents byte req_data[8i+7:8i]
//   req_ack                 : one-cycle capture pulse per requester
//   tx_start/tx_data/tx_busy: transmitter handshake
//   grant_valid/grant_id    : frame lock status
//   err_clr/timeout_err     : sticky "transmitter never went busy" flag
// master: the environment (requesters + transmitter); slave: the arbiter.
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = 2
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ack;
  logic                 tx_busy;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 grant_valid;
  logic [IDW-1:0]       grant_id;
  logic                 err_clr;
  logic                 timeout_err;

  modport master (
    output req, req_data, req_last, tx_busy, err_clr,
    input  req_ack, tx_start, tx_data, grant_valid, grant_id, timeout_err
  );

  modport slave (
    input  req, req_data, req_last, tx_busy, err_clr,
    output req_ack, tx_start, tx_data, grant_valid, grant_id, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between NUM_REQ byte-stream requesters.
// Round-robin arbitration with frame locking: once a requester wins, only it
// is served until it sends a byte flagged req_last (or the byte times out).
// Each byte goes through IDLE -> START -> WAIT_BUSY -> WAIT_DONE; a
// transmitter that never raises tx_busy within BUSY_TIMEOUT cycles aborts
// the frame and sets the sticky timeout_err.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : uart_tx_arbiter_if.slave (requesters, transmitter, status)
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned IDW          = 2,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned    CNT_W       = 8;
  localparam logic [IDW-1:0] PTR_RST     = IDW'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [IDW-1:0]     r_ptr;
  logic [IDW-1:0]     r_grant_id;
  logic               r_grant_valid;
  logic               r_last;
  logic               r_tx_start;
  logic [7:0]         r_tx_data;
  logic [NUM_REQ-1:0] r_req_ack;
  logic               r_timeout_err;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_rr_hit;
  logic [IDW-1:0]     w_rr_idx;
  logic               w_sel_hit;
  logic [IDW-1:0]     w_sel_idx;
  logic [CNT_W-1:0]   w_cnt_inc;

  // Round-robin search: first set req bit strictly after r_ptr, wrapping.
  always_comb begin
    int unsigned idx;
    w_rr_hit = 1'b0;
    w_rr_idx = '0;
    idx      = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = 32'(r_ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!w_rr_hit && bus.req[IDW'(idx)]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = IDW'(idx);
      end
    end
  end

  // While a frame lock is held only the owner is eligible.
  always_comb begin
    w_sel_hit = w_rr_hit;
    w_sel_idx = w_rr_idx;
    if (r_grant_valid) begin
      w_sel_hit = bus.req[r_grant_id];
      w_sel_idx = r_grant_id;
    end
  end

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Byte sequencer, grant/lock tracking and sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_ptr         <= PTR_RST;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_last        <= 1'b0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= 8'h00;
      r_req_ack     <= '0;
      r_timeout_err <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_req_ack  <= '0;
      r_tx_start <= 1'b0;

      // A timeout set later in this block overrides the clear.
      if (bus.err_clr) begin
        r_timeout_err <= 1'b0;
      end

      unique case (r_state)
        S_IDLE: begin
          if (w_sel_hit) begin
            r_tx_data             <= bus.req_data[8*w_sel_idx +: 8];
            r_last                <= bus.req_last[w_sel_idx];
            r_grant_id            <= w_sel_idx;
            r_grant_valid         <= 1'b1;
            r_ptr                 <= w_sel_idx;
            r_req_ack[w_sel_idx]  <= 1'b1;
            // tx_start is high exactly while the sequencer sits in START.
            r_tx_start            <= 1'b1;
            r_state               <= S_START;
          end
        end

        S_START: begin
          r_cnt   <= '0;
          r_state <= S_WAIT_BUSY;
        end

        S_WAIT_BUSY: begin
          if (bus.tx_busy) begin
            r_state <= S_WAIT_DONE;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == TIMEOUT_LIM) begin
              // Transmitter never accepted the byte: abort the frame.
              r_timeout_err <= 1'b1;
              r_grant_valid <= 1'b0;
              r_state       <= S_IDLE;
            end
          end
        end

        S_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            r_state <= S_IDLE;
            if (r_last) begin
              r_grant_valid <= 1'b0;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ack     = r_req_ack;
  assign bus.tx_start    = r_tx_start;
  assign bus.tx_data     = r_tx_data;
  assign bus.grant_valid = r_grant_valid;
  assign bus.grant_id    = r_grant_id;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

- Shares the single UART transmitter between NUM_REQ byte-stream requesters (command responder, vision telemetry, debug dump, …).
- Arbitration is round-robin with frame locking, so one requester's multi-byte frame never interleaves with another's.
- Drives the transmitter with the team's standard tx_start/tx_busy handshake, and flags a transmitter that never goes busy.

## Interface
- NUM_REQ, 4, number of requesters (2–8).
- IDW, 2, width of grant_id; must equal clog2(NUM_REQ).
- BUSY_TIMEOUT, 15, number of WAIT_BUSY cycles with tx_busy=0 before the byte is abandoned (1–255).
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req  in  NUM_REQ  bit i: requester i presents a byte.
- req_data  in  8*NUM_REQ  byte of requester i on [8i+7:8i].
- req_last  in  NUM_REQ  bit i: that byte ends requester i's frame.
- req_ack  out  NUM_REQ  one-cycle pulse: byte of requester i captured.
- tx_busy  in  1  transmitter busy.
- tx_start  out  1  one-cycle pulse: tx_data is ready to send.
- tx_data  out  8  byte to transmit.
- grant_valid  out  1  a frame lock is held.
- grant_id  out  IDW  current or most recent frame owner.
- err_clr  in  1  clears timeout_err.
- timeout_err  out  1  sticky: transmitter failed to go busy.

## Operation
- States: IDLE, START, WAIT_BUSY, WAIT_DONE.
- **IDLE, lock free.** Search req from (ptr+1) mod NUM_REQ upward, wrapping around. On the first set bit i:
  - load tx_data <= req_data[i] and record last <= req_last[i];
  - set grant_id <= i, grant_valid <= 1, ptr <= i;
  - pulse req_ack[i] and go to START.
- **IDLE, lock held.** Only req[grant_id] is considered. Other requests wait indefinitely, even if the owner's req is low.
- **START.** tx_start=1, decoded combinationally from state. Clear the timeout counter and go to WAIT_BUSY.
- **WAIT_BUSY.**
  - tx_busy=1: go to WAIT_DONE.
  - tx_busy=0: increment the counter. When the counter reaches BUSY_TIMEOUT: set timeout_err, clear grant_valid (frame aborted), go to IDLE.
- **WAIT_DONE.** When tx_busy=0, go to IDLE. If last=1, clear grant_valid on that same edge.
- **Requester contract.** Hold req, req_data and req_last stable until req_ack. After req_ack the next byte may be presented immediately.
- **Single-byte frames.** A byte with req_last=1 as the first byte of a frame locks and releases within that byte.
- **Error flag.** timeout_err is cleared by err_clr=1. If err_clr and a new timeout occur on the same edge, the set wins.
- **Pointer.** ptr resets to NUM_REQ-1, so requester 0 has first priority after reset.
- **Reset.** Takes effect immediately, including mid-transfer:
  - state = IDLE, tx_start=0, req_ack=0, tx_data=0x00;
  - grant_valid=0, grant_id=0, timeout_err=0;
  - timeout counter=0, last=0.
  - Any frame in progress is dropped; the transmitter finishes its byte independently.

## Timing
- Byte selected on edge E (req sampled in IDLE). In cycle E+1: req_ack[i]=1, tx_start=1, tx_data valid.
- tx_data holds its value from E+1 until the next selection edge.
- tx_start is high for exactly one cycle per byte. It is never reasserted before tx_busy has been seen high and then low.
- Minimum per-byte occupancy is 4 cycles (IDLE, START, WAIT_BUSY, WAIT_DONE) plus the transmitter's busy time.
- The next selection happens the cycle after tx_busy falls is observed in WAIT_DONE.
- tx_busy already high on entry to WAIT_BUSY: exits on the next edge with no timeout.
- Timeout: the abort edge is START + 1 + BUSY_TIMEOUT cycles. With default 15, the arbiter is back in IDLE 16 cycles after tx_start.
- A req asserted during START, WAIT_BUSY or WAIT_DONE is not acked until the following IDLE.

## Test plan
1. Single byte:
   - Stimulus: req[1]=1, req_data=0x5A, req_last[1]=1; transmitter raises busy 1 cycle after tx_start for 10 cycles.
   - Required: one req_ack[1] pulse coincident with tx_start; tx_data=0x5A; grant_id=1; grant_valid falls when busy falls.
2. Round robin:
   - Stimulus: req[0] and req[2] held with single-byte frames 0xA0 and 0xA2; afterwards req[0] and req[3] held.
   - Required: first pair sent in order 0xA0, 0xA2; with ptr=2, the second pair serves requester 3 before requester 0.
3. Frame lock:
   - Stimulus: requester 0 sends 0x10, 0x11, 0x12 (last on 0x12) while req[1] is held with 0x20.
   - Required: tx_data sequence 0x10, 0x11, 0x12, 0x20; req_ack[1] is never asserted before the third byte completes.
4. Timeout:
   - Stimulus: tx_busy held 0 with BUSY_TIMEOUT=15.
   - Required: timeout_err rises 16 cycles after tx_start; grant_valid=0; the next pending request is served.
   - Then pulse err_clr together with a second timeout event: timeout_err stays 1.
5. Reset mid-transfer:
   - Stimulus: assert reset low in WAIT_DONE of a multi-byte frame, without waiting for a clock edge.
   - Required: all outputs take reset values immediately; after release, requester 0 wins a simultaneous 0/3 request.
